// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit-side arbiter and its helpers.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int GRANT_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOW,
    WAIT_HIGH
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// the last winner, wrapping modulo N. Reusable by any shared-resource arbiter.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]       req,
  input  logic [GRANT_W-1:0] last,
  output logic [GRANT_W-1:0] winner,
  output logic               valid
);

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    int cand;
    winner = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int off = 1; off <= N; off++) begin
      cand = int'(last) + off;
      if (cand >= N) cand -= N;
      for (int i = 0; i < N; i++) begin
        if (!valid && i == cand && req[i]) begin
          winner = GRANT_W'(i);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte producers,
// with a watchdog on the transmitter accepting each byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ACCEPT_TIMEOUT = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           uart_send_req,
  output logic [UART_DATA_W-1:0]         uart_data,
  input  logic                           uart_ready,
  output logic                           busy,
  output logic [GRANT_W-1:0]             grant_idx,
  output logic                           err
);

  localparam int                  TIMER_W    = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(ACCEPT_TIMEOUT - 1);
  localparam logic [GRANT_W-1:0]  RESET_IDX  = GRANT_W'(NUM_REQ - 1);

  state_t                   state, next_state;
  logic [TIMER_W-1:0]       timer, next_timer;
  logic                     pick_valid;
  logic [GRANT_W-1:0]       pick_idx;
  logic [UART_DATA_W-1:0]   pick_data;
  logic [NUM_REQ-1:0]       pick_onehot;
  logic                     grant_now;
  logic                     timeout_now;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (req),
    .last   (grant_idx),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_data   = '0;
    pick_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == GRANT_W'(i)) begin
        pick_data      = req_data[i*UART_DATA_W +: UART_DATA_W];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    next_state  = state;
    next_timer  = timer;
    grant_now   = 1'b0;
    timeout_now = 1'b0;
    case (state)
      IDLE: begin
        if (uart_ready && pick_valid) begin
          grant_now  = 1'b1;
          next_timer = '0;
          next_state = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // Timer never passes the terminal count: reaching it leaves the state.
        if (!uart_ready) begin
          next_state = WAIT_HIGH;
        end else if (timer == TIMER_LAST) begin
          timeout_now = 1'b1;
          next_state  = IDLE;
        end else begin
          next_timer = timer + TIMER_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (uart_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      ack           <= '0;
      uart_send_req <= 1'b0;
      uart_data     <= '0;
      busy          <= 1'b0;
      grant_idx     <= RESET_IDX;
      err           <= 1'b0;
    end else begin
      state         <= next_state;
      timer         <= next_timer;
      ack           <= grant_now ? pick_onehot : '0;
      uart_send_req <= grant_now;
      err           <= timeout_now;
      busy          <= (next_state != IDLE);
      if (grant_now) begin
        uart_data <= pick_data;
        grant_idx <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural transmitter
// whose ready line can run normal frames, stick high or be held low.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int FRAME   = 10;
  localparam int TIMEOUT = 15;
  localparam int LIMIT   = 60;

  typedef enum {TX_NORMAL, TX_STUCK, TX_LOW} tx_mode_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req = '0;
  logic [31:0]  req_data = '0;
  logic [3:0]   ack;
  logic         uart_send_req;
  logic [7:0]   uart_data;
  logic         uart_ready = 1'b1;
  logic         busy;
  logic [2:0]   grant_idx;
  logic         err;

  tx_mode_t tx_mode = TX_NORMAL;
  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ACCEPT_TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .uart_send_req (uart_send_req),
    .uart_data     (uart_data),
    .uart_ready    (uart_ready),
    .busy          (busy),
    .grant_idx     (grant_idx),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Transmitter: pulse seen in the send cycle, ready drops after the next
  // edge and stays low for FRAME cycles.
  initial begin : tx_model
    bit pending;
    int cnt;
    pending = 1'b0;
    cnt     = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        uart_ready = 1'b1;
        pending    = 1'b0;
        cnt        = 0;
      end else begin
        case (tx_mode)
          TX_STUCK: begin uart_ready = 1'b1; pending = 1'b0; cnt = 0; end
          TX_LOW:   begin uart_ready = 1'b0; pending = 1'b0; cnt = 0; end
          default: begin
            if (pending) begin
              uart_ready = 1'b0;
              cnt        = FRAME;
              pending    = 1'b0;
            end else if (cnt > 0) begin
              cnt--;
              if (cnt == 0) uart_ready = 1'b1;
            end else begin
              uart_ready = 1'b1;
            end
            if (uart_send_req) pending = 1'b1;
          end
        endcase
      end
    end
  end

  initial begin : global_watchdog
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ack"},       32'(ack), 32'h0);
    check({tag, " send"},      32'(uart_send_req), 32'h0);
    check({tag, " data"},      32'(uart_data), 32'h0);
    check({tag, " busy"},      32'(busy), 32'h0);
    check({tag, " grant_idx"}, 32'(grant_idx), 32'd3);
    check({tag, " err"},       32'(err), 32'h0);
  endtask

  task automatic wait_send(input string tag, output int steps, output int acks);
    bit seen;
    seen  = 1'b0;
    steps = 0;
    acks  = 0;
    for (int i = 0; i < LIMIT && !seen; i++) begin
      @(negedge clk);
      steps++;
      if (ack != '0) acks++;
      if (uart_send_req) seen = 1'b1;
    end
    check({tag, " send seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < LIMIT && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    check({tag, " idle"}, 32'(idle), 32'd1);
  endtask

  task automatic wait_err(input string tag, output int steps);
    bit seen;
    seen  = 1'b0;
    steps = 0;
    for (int i = 0; i < LIMIT && !seen; i++) begin
      @(negedge clk);
      steps++;
      if (err) seen = 1'b1;
    end
    check({tag, " err seen"}, 32'(seen), 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : stim
    int steps, acks, sends;

    #1 reset = 1'b1;
    #2 check_reset("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single request from requester 2.
    req      = 4'b0100;
    req_data = 32'h00A5_0000;
    wait_send("single", steps, acks);
    check("single ack",   32'(ack), 32'h4);
    check("single data",  32'(uart_data), 32'hA5);
    check("single grant", 32'(grant_idx), 32'd2);
    check("single busy",  32'(busy), 32'd1);
    req = '0;
    @(negedge clk);
    check("single send pulse width", 32'(uart_send_req), 32'd0);
    check("single ack pulse width",  32'(ack), 32'h0);
    repeat (FRAME) @(negedge clk);
    check("single busy in frame", 32'(busy), 32'd1);
    check("single data stable",   32'(uart_data), 32'hA5);
    @(negedge clk);
    check("single busy drop", 32'(busy), 32'd0);

    // All requesters held: rotation 0,1,2,3,0 from reset.
    apply_reset();
    check("rr reset grant_idx", 32'(grant_idx), 32'd3);
    req      = 4'b1111;
    req_data = 32'h1312_1110;
    for (int k = 0; k < 5; k++) begin
      wait_send($sformatf("rr%0d", k), steps, acks);
      check($sformatf("rr%0d data", k),  32'(uart_data), 32'h10 + 32'(k % 4));
      check($sformatf("rr%0d ack", k),   32'(ack), 32'd1 << (k % 4));
      check($sformatf("rr%0d grant", k), 32'(grant_idx), 32'(k % 4));
      check($sformatf("rr%0d acks per frame", k), 32'(acks), 32'd1);
      if (k > 0) check($sformatf("rr%0d gap", k), 32'(steps), 32'(FRAME + 3));
    end
    req = '0;
    wait_idle("rr");

    // Back-to-back from requester 0 with new data after ack.
    req      = 4'b0001;
    req_data = 32'h0000_0033;
    wait_send("b2b first", steps, acks);
    check("b2b first data",  32'(uart_data), 32'h33);
    check("b2b first grant", 32'(grant_idx), 32'd0);
    @(negedge clk);
    req_data = 32'h0000_0055;
    wait_send("b2b second", steps, acks);
    check("b2b second gap",  32'(steps), 32'(FRAME + 2));
    check("b2b second data", 32'(uart_data), 32'h55);
    check("b2b second ack",  32'(ack), 32'h1);
    req = '0;
    wait_idle("b2b");

    // Stuck transmitter: watchdog fires, then normal grant resumes.
    tx_mode  = TX_STUCK;
    req      = 4'b0010;
    req_data = 32'h0000_7700;
    wait_send("stuck", steps, acks);
    check("stuck ack",   32'(ack), 32'h2);
    check("stuck data",  32'(uart_data), 32'h77);
    check("stuck grant", 32'(grant_idx), 32'd1);
    req = '0;
    wait_err("stuck", steps);
    check("stuck err delay", 32'(steps), 32'(TIMEOUT));
    check("stuck busy drop", 32'(busy), 32'd0);
    tx_mode  = TX_NORMAL;
    req      = 4'b1000;
    req_data = 32'h8800_0000;
    wait_send("post stuck", steps, acks);
    check("post stuck err pulse width", 32'(err), 32'd0);
    check("post stuck ack",   32'(ack), 32'h8);
    check("post stuck data",  32'(uart_data), 32'h88);
    check("post stuck grant", 32'(grant_idx), 32'd3);
    req = '0;
    wait_idle("post stuck");

    // Transmitter busy when the request arrives.
    tx_mode = TX_LOW;
    repeat (2) @(negedge clk);
    req      = 4'b0001;
    req_data = 32'h0000_0042;
    sends = 0;
    repeat (6) begin
      @(negedge clk);
      if (uart_send_req) sends++;
    end
    check("txbusy no send", 32'(sends), 32'd0);
    @(posedge clk);
    #1 tx_mode = TX_NORMAL;
    @(negedge clk);
    check("txbusy ready edge no send", 32'(uart_send_req), 32'd0);
    @(negedge clk);
    check("txbusy send", 32'(uart_send_req), 32'd1);
    check("txbusy ack",  32'(ack), 32'h1);
    check("txbusy data", 32'(uart_data), 32'h42);
    check("txbusy grant", 32'(grant_idx), 32'd0);
    req = '0;

    // Reset in WAIT_HIGH, no clock edge before the outputs are checked.
    repeat (5) @(negedge clk);
    check("midreset busy before", 32'(busy), 32'd1);
    req      = 4'b1001;
    req_data = 32'hC300_005A;
    #2 reset = 1'b1;
    #1 check_reset("midreset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_send("midreset first", steps, acks);
    check("midreset first ack",   32'(ack), 32'h1);
    check("midreset first data",  32'(uart_data), 32'h5A);
    check("midreset first grant", 32'(grant_idx), 32'd0);
    req = '0;
    wait_idle("midreset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
